// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, FSM state codes and config addresses for the PID sequencer.
package pid_pkg;
    localparam int W = 16;
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_FAULT = 2'b10;
    localparam logic [1:0] ADDR_KP  = 2'd0;
    localparam logic [1:0] ADDR_KI  = 2'd1;
    localparam logic [1:0] ADDR_KD  = 2'd2;
    localparam logic [1:0] ADDR_SV  = 2'd3;
endpackage

// File: rtl/pid_sv_ramp.sv
// pid_sv_ramp: slew limiter giving the next setpoint one bounded step toward target, never overshooting.
module pid_sv_ramp
    import pid_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic [W-1:0] target_i,
    input  logic [W-1:0] cur_i,
    output logic [W-1:0] next_o
);
    localparam logic [W-1:0] STEP_W = W'(STEP);
    logic         up;
    logic [W-1:0] diff;
    always_comb begin
        up     = target_i > cur_i;
        diff   = up ? target_i - cur_i : cur_i - target_i;
        next_o = diff <= STEP_W ? target_i : (up ? cur_i + STEP_W : cur_i - STEP_W);
    end
endmodule

// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer: shadows host config, applies it on sample ticks, ramps the setpoint
// and trips to FAULT after persistent core overflow.
module pid_loop_sequencer
    import pid_pkg::*;
#(
    parameter int unsigned PERIOD      = 100,
    parameter int unsigned RAMP_STEP   = 4,
    parameter int unsigned FAULT_LIMIT = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         fault_clr,
    input  logic         cfg_valid,
    output logic         cfg_ready,
    input  logic [1:0]   cfg_addr,
    input  logic [W-1:0] cfg_data,
    input  logic         cfg_commit,
    input  logic [3:0]   of_in,
    output logic [W-1:0] Kp_out,
    output logic [W-1:0] Ki_out,
    output logic [W-1:0] Kd_out,
    output logic [W-1:0] SV_out,
    output logic         core_rst_n,
    output logic         sample_tick,
    output logic         fault,
    output logic [1:0]   state
);
    localparam int CW = $clog2(PERIOD);
    localparam int FW = $clog2(FAULT_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);
    localparam logic [FW-1:0] FL_V    = FW'(FAULT_LIMIT);

    logic [1:0]    state_q, state_d;
    logic [W-1:0]  sh_q [4];
    logic [W-1:0]  kp_q, ki_q, kd_q, tgt_q, tgt_d, sv_q, sv_d, ramp_next;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] fcnt_q, fcnt_d, fcnt_t;
    logic          pend_q, pend_d, ready_q, tick_q, tick_d, crst_q, fault_q;
    logic          wr, trip, start, stay_run, gain_ld, tgt_ld;

    pid_sv_ramp #(.STEP(RAMP_STEP)) u_ramp (
        .target_i (tgt_d),
        .cur_i    (sv_q),
        .next_o   (ramp_next)
    );

    // tick_q marks the sample cycle; its actions land in the registers one cycle later.
    always_comb begin
        wr       = cfg_valid & ready_q;
        fcnt_t   = |of_in ? (fcnt_q == FL_V ? fcnt_q : fcnt_q + 1'b1) : '0;
        trip     = tick_q && fcnt_t == FL_V;
        state_d  = state_q == ST_RUN   ? (trip ? ST_FAULT : enable ? ST_RUN : ST_IDLE)
                 : state_q == ST_FAULT ? (fault_clr ? ST_IDLE : ST_FAULT)
                 : (enable ? ST_RUN : ST_IDLE);
        start    = state_d == ST_RUN && state_q != ST_RUN;
        stay_run = state_d == ST_RUN && state_q == ST_RUN;
        gain_ld  = start || (tick_q && pend_q);
        tgt_ld   = pend_q && (start || tick_q);
        tgt_d    = tgt_ld ? sh_q[ADDR_SV] : tgt_q;
        sv_d     = state_d != ST_RUN ? '0 : tick_q ? ramp_next : sv_q;
        pend_d   = (wr && cfg_commit) ? 1'b1 : tgt_ld ? 1'b0 : pend_q;
        cnt_d    = stay_run ? (cnt_q == CNT_MAX ? '0 : cnt_q + 1'b1) : '0;
        tick_d   = stay_run && cnt_q == CNT_MAX;
        fcnt_d   = (state_q == ST_FAULT && fault_clr) ? '0 : tick_q ? fcnt_t : fcnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '{default: '0};
            kp_q    <= '0;
            ki_q    <= '0;
            kd_q    <= '0;
            tgt_q   <= '0;
            sv_q    <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
            pend_q  <= 1'b0;
            ready_q <= 1'b1;
            tick_q  <= 1'b0;
            crst_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (wr) sh_q[cfg_addr] <= cfg_data;
            kp_q    <= gain_ld ? sh_q[ADDR_KP] : kp_q;
            ki_q    <= gain_ld ? sh_q[ADDR_KI] : ki_q;
            kd_q    <= gain_ld ? sh_q[ADDR_KD] : kd_q;
            tgt_q   <= tgt_d;
            sv_q    <= sv_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            pend_q  <= pend_d;
            ready_q <= !pend_d;
            tick_q  <= tick_d;
            crst_q  <= state_d == ST_RUN;
            fault_q <= state_d == ST_FAULT;
        end
    end

    assign cfg_ready   = ready_q;
    assign Kp_out      = kp_q;
    assign Ki_out      = ki_q;
    assign Kd_out      = kd_q;
    assign SV_out      = sv_q;
    assign core_rst_n  = crst_q;
    assign sample_tick = tick_q;
    assign fault       = fault_q;
    assign state       = state_q;
endmodule

// File: tb/tb_pid_loop_sequencer.sv
// tb_pid_loop_sequencer: directed sequence with random data checked against a tick-level behavioural model.
module tb_pid_loop_sequencer;
    localparam int PERIOD = 10;
    localparam int STEP   = 4;
    localparam int FL     = 3;

    logic        clk = 1'b0, rst, enable, fault_clr, cfg_valid, cfg_commit;
    logic [1:0]  cfg_addr;
    logic [15:0] cfg_data;
    logic [3:0]  of_in;
    logic        cfg_ready, core_rst_n, sample_tick, fault;
    logic [15:0] Kp_out, Ki_out, Kd_out, SV_out;
    logic [1:0]  state;

    pid_loop_sequencer #(.PERIOD(PERIOD), .RAMP_STEP(STEP), .FAULT_LIMIT(FL)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fault_clr(fault_clr),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
        .cfg_data(cfg_data), .cfg_commit(cfg_commit), .of_in(of_in),
        .Kp_out(Kp_out), .Ki_out(Ki_out), .Kd_out(Kd_out), .SV_out(SV_out),
        .core_rst_n(core_rst_n), .sample_tick(sample_tick), .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc = 0, t_ref = 0;
    int sh[4], act[3], tgt, sv, fcnt, mst;
    bit pend;
    int g_kp, g_ki, rnd_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic chk_core(input string tag);
        chk({tag, ".Kp"}, 32'(Kp_out), act[0]);
        chk({tag, ".Ki"}, 32'(Ki_out), act[1]);
        chk({tag, ".Kd"}, 32'(Kd_out), act[2]);
        chk({tag, ".SV"}, 32'(SV_out), sv);
        chk({tag, ".ready"}, 32'(cfg_ready), 32'(!pend));
        chk({tag, ".state"}, 32'(state), mst);
    endtask

    task automatic wr(input int a, input int d, input bit c);
        int n = 0;
        while (cfg_ready !== 1'b1 && n < 4 * PERIOD) begin
            step();
            n++;
        end
        chk("wr_ready", 32'(cfg_ready), 1);
        cfg_valid = 1; cfg_addr = 2'(a); cfg_data = 16'(d); cfg_commit = c;
        step();
        cfg_valid = 0; cfg_commit = 0;
        sh[a] = d;
        if (c) pend = 1;
    endtask

    task automatic enter_run(input string tag);
        enable = 1;
        step();
        for (int i = 0; i < 3; i++) act[i] = sh[i];
        if (pend) tgt = sh[3];
        pend = 0; sv = 0; mst = 1;
        t_ref = cyc;
        chk_core(tag);
        chk({tag, ".core_rst_n"}, 32'(core_rst_n), 1);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (sample_tick !== 1'b1 && n < 3 * PERIOD) begin
            step();
            n++;
        end
        chk({tag, ".period"}, cyc - t_ref, PERIOD);
        t_ref = cyc;
    endtask

    task automatic tick_model();
        if (pend) begin
            for (int i = 0; i < 3; i++) act[i] = sh[i];
            tgt = sh[3];
            pend = 0;
        end
        sv = tgt > sv ? (sv + STEP < tgt ? sv + STEP : tgt) : (sv - STEP > tgt ? sv - STEP : tgt);
        fcnt = of_in != 0 ? (fcnt + 1 > FL ? FL : fcnt + 1) : 0;
        if (fcnt == FL) begin
            mst = 2;
            sv = 0;
        end
    endtask

    task automatic run_ticks(input string tag, input int k);
        repeat (k) begin
            wait_tick(tag);
            tick_model();
            step();
            chk_core(tag);
            chk({tag, ".pulse"}, 32'(sample_tick), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; enable = 0; fault_clr = 0; cfg_valid = 0; cfg_commit = 0;
        cfg_addr = 0; cfg_data = 0; of_in = 0;
        for (int i = 0; i < 4; i++) sh[i] = 0;
        for (int i = 0; i < 3; i++) act[i] = 0;
        tgt = 0; sv = 0; fcnt = 0; mst = 0; pend = 0;
        step(2);
        chk_core("reset");
        chk("reset.core_rst_n", 32'(core_rst_n), 0);
        chk("reset.fault", 32'(fault), 0);
        chk("reset.tick", 32'(sample_tick), 0);
        rst = 0;
        step();

        // ramp up to 20 from committed config
        wr(0, $urandom_range(0, 65535), 0);
        wr(1, $urandom_range(0, 65535), 0);
        wr(2, $urandom_range(0, 65535), 0);
        wr(3, 20, 1);
        chk_core("idle_commit");
        enter_run("t1.entry");
        for (int n = 1; n <= 7; n++) begin
            wait_tick("t1");
            tick_model();
            step();
            chk_core("t1");
            chk("t1.sv_seq", 32'(SV_out), n * STEP < 20 ? n * STEP : 20);
        end

        // gain writes stay shadowed until the tick after the commit
        g_kp = $urandom_range(0, 65535);
        g_ki = $urandom_range(0, 65535);
        wr(0, g_kp, 0);
        step(2);
        wr(1, g_ki, 1);
        chk_core("t2.hold");
        wait_tick("t2");
        chk_core("t2.at_tick");
        tick_model();
        step();
        chk_core("t2.applied");
        chk("t2.kp_new", 32'(Kp_out), g_kp);
        chk("t2.ki_new", 32'(Ki_out), g_ki);

        // ramp down to 2
        wr(3, 2, 1);
        for (int n = 1; n <= 6; n++) begin
            wait_tick("t3");
            tick_model();
            step();
            chk_core("t3");
            chk("t3.sv_seq", 32'(SV_out), 20 - n * STEP > 2 ? 20 - n * STEP : 2);
        end

        // random target
        rnd_t = $urandom_range(0, 200);
        wr(3, rnd_t, 1);
        run_ticks("t3r", (rnd_t > 2 ? rnd_t - 2 : 2 - rnd_t) / STEP + 2);
        chk("t3r.final", 32'(SV_out), rnd_t);

        // overflow streak broken, then persistent overflow with enable falling at the trip
        of_in = 4'($urandom_range(1, 15));
        run_ticks("t4.of", 2);
        of_in = 0;
        run_ticks("t4.clear", 1);
        of_in = 4'b0001;
        run_ticks("t4.of2", FL - 1);
        wait_tick("t4.trip");
        enable = 0;
        tick_model();
        step();
        chk_core("t4.fault");
        chk("t4.fault_flag", 32'(fault), 1);
        chk("t4.core_rst_n", 32'(core_rst_n), 0);

        // FAULT ignores enable until cleared
        enable = 1;
        step(5);
        chk("t5.stay", 32'(state), 2);
        chk("t5.no_tick", 32'(sample_tick), 0);
        of_in = 0;
        fault_clr = 1;
        step();
        fault_clr = 0;
        mst = 0; fcnt = 0;
        chk_core("t5.idle");
        chk("t5.fault_low", 32'(fault), 0);
        chk("t5.core_rst_n", 32'(core_rst_n), 0);
        enter_run("t5.entry");
        run_ticks("t5.ramp", 2);

        // RUN->IDLE retains gains; target committed in IDLE applies at entry
        enable = 0;
        step();
        mst = 0; sv = 0;
        chk_core("t5.to_idle");
        chk("t5.idle_core_rst_n", 32'(core_rst_n), 0);
        wr(3, $urandom_range(0, 200), 1);
        enter_run("t5.reentry");
        run_ticks("t5.ramp2", 3);

        // reset mid-ramp with a commit pending
        wr(3, $urandom_range(0, 200), 1);
        step(2);
        rst = 1;
        step();
        for (int i = 0; i < 4; i++) sh[i] = 0;
        for (int i = 0; i < 3; i++) act[i] = 0;
        tgt = 0; sv = 0; fcnt = 0; mst = 0; pend = 0;
        chk_core("t6.reset");
        chk("t6.core_rst_n", 32'(core_rst_n), 0);
        chk("t6.tick", 32'(sample_tick), 0);
        rst = 0;
        enter_run("t6.entry");
        run_ticks("t6.after", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
